// File: rtl/cpu_mem_if.sv
// CPU memory bus plus byte-stream loader signals between the CPU side and the memory responder.
interface cpu_mem_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
);
  logic [ADDR_W-1:0] cpu_addr;
  logic              cpu_rd;
  logic              cpu_wr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_hold;
  logic              prog_valid;
  logic [DATA_W-1:0] prog_data;
  logic              prog_ready;
  logic              prog_skip;
  logic [ADDR_W:0]   load_count;
  logic              access_err;

  modport master (
    output cpu_addr, cpu_rd, cpu_wr, cpu_wdata, prog_valid, prog_data, prog_skip,
    input  cpu_rdata, cpu_hold, prog_ready, load_count, access_err
  );

  modport slave (
    input  cpu_addr, cpu_rd, cpu_wr, cpu_wdata, prog_valid, prog_data, prog_skip,
    output cpu_rdata, cpu_hold, prog_ready, load_count, access_err
  );
endinterface

// File: rtl/cpu_mem_responder.sv
// Memory-side responder for the CPU: byte store with 1-cycle registered read, CPU writes,
// and a post-reset byte loader that holds the CPU in reset until the image is in place.
module cpu_mem_responder #(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned DEPTH    = 256,
  parameter int unsigned LOAD_LEN = 256
) (
  input  logic      clk,
  input  logic      rst,
  cpu_mem_if.slave  bus
);

  localparam int unsigned     LastIdxInt = LOAD_LEN - 1;
  localparam logic [ADDR_W:0] LastIdx    = LastIdxInt[ADDR_W:0];

  typedef enum logic [0:0] {StLoad, StRun} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              load_we, run_we;

  logic [DATA_W-1:0] mem [DEPTH];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = '0;
    err_d   = err_q;
    load_we = 1'b0;
    run_we  = 1'b0;
    case (state_q)
      StLoad: begin
        // CPU is still held; any access is flagged and never reaches the store.
        if (bus.cpu_rd || bus.cpu_wr) err_d = 1'b1;
        load_we = bus.prog_valid;
        if (bus.prog_valid) cnt_d = cnt_q + 1'b1;
        if ((bus.prog_valid && (cnt_q == LastIdx)) || bus.prog_skip) state_d = StRun;
      end
      StRun: begin
        run_we = bus.cpu_wr;
        if (bus.cpu_rd) rdata_d = mem[bus.cpu_addr];
      end
      default: state_d = StLoad;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StLoad;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Contents survive reset; only writes are suppressed while rst is high.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (load_we) begin
        mem[cnt_q[ADDR_W-1:0]] <= bus.prog_data;
      end else if (run_we) begin
        mem[bus.cpu_addr] <= bus.cpu_wdata;
      end
    end
  end

  assign bus.cpu_rdata  = rdata_q;
  assign bus.load_count = cnt_q;
  assign bus.access_err = err_q;
  assign bus.cpu_hold   = (state_q == StLoad);
  assign bus.prog_ready = (state_q == StLoad);

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Self-checking bench for cpu_mem_responder: directed scenarios plus randomized traffic
// compared against a transaction-level reference model.
module tb_cpu_mem_responder;

  localparam int unsigned LoadLen = 3;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  cpu_mem_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  cpu_mem_responder #(
    .ADDR_W  (8),
    .DATA_W  (8),
    .DEPTH   (256),
    .LOAD_LEN(LoadLen)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  bit         m_run;
  int         m_cnt;
  bit         m_err;
  logic [7:0] m_rdata;
  logic [7:0] m_mem [256];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance the model by one clock using the inputs currently applied, then compare.
  task automatic step();
    if (rst) begin
      m_run   = 1'b0;
      m_cnt   = 0;
      m_rdata = 8'h00;
      m_err   = 1'b0;
    end else if (!m_run) begin
      m_rdata = 8'h00;
      if (bus.cpu_rd || bus.cpu_wr) m_err = 1'b1;
      if (bus.prog_valid) begin
        m_mem[m_cnt] = bus.prog_data;
        m_cnt++;
      end
      if (m_cnt == LoadLen || bus.prog_skip) m_run = 1'b1;
    end else begin
      m_rdata = bus.cpu_rd ? m_mem[bus.cpu_addr] : 8'h00;
      if (bus.cpu_wr) m_mem[bus.cpu_addr] = bus.cpu_wdata;
    end
    @(posedge clk);
    #1;
    check("rdata", 32'(bus.cpu_rdata), 32'(m_rdata));
    check("hold", 32'(bus.cpu_hold), 32'(!m_run));
    check("ready", 32'(bus.prog_ready), 32'(!m_run));
    check("count", 32'(bus.load_count), 32'(m_cnt));
    check("err", 32'(bus.access_err), 32'(m_err));
  endtask

  task automatic idle();
    rst            = 1'b0;
    bus.cpu_addr   = 8'h00;
    bus.cpu_rd     = 1'b0;
    bus.cpu_wr     = 1'b0;
    bus.cpu_wdata  = 8'h00;
    bus.prog_valid = 1'b0;
    bus.prog_data  = 8'h00;
    bus.prog_skip  = 1'b0;
  endtask

  task automatic read_one(input logic [7:0] addr, input logic [7:0] exp, input string tag);
    bus.cpu_addr = addr;
    bus.cpu_rd   = 1'b1;
    step();
    bus.cpu_rd = 1'b0;
    check(tag, 32'(bus.cpu_rdata), 32'(exp));
  endtask

  initial begin
    idle();
    rst = 1'b1;
    step();
    step();
    check("rst_hold", 32'(bus.cpu_hold), 32'd1);
    check("rst_ready", 32'(bus.prog_ready), 32'd1);
    check("rst_count", 32'(bus.load_count), 32'd0);
    check("rst_rdata", 32'(bus.cpu_rdata), 32'd0);

    // Load 3 bytes back-to-back
    rst            = 1'b0;
    bus.prog_valid = 1'b1;
    bus.prog_data  = 8'h10;
    step();
    check("ld1_hold", 32'(bus.cpu_hold), 32'd1);
    bus.prog_data = 8'h20;
    step();
    check("ld2_ready", 32'(bus.prog_ready), 32'd1);
    bus.prog_data = 8'h30;
    step();
    check("ld3_hold", 32'(bus.cpu_hold), 32'd0);
    check("ld3_ready", 32'(bus.prog_ready), 32'd0);
    check("ld3_count", 32'(bus.load_count), 32'd3);
    bus.prog_data = 8'h99;
    step();
    check("ld_frozen", 32'(bus.load_count), 32'd3);
    bus.prog_valid = 1'b0;

    // Read latency and return to zero
    read_one(8'd1, 8'h20, "rd_a1");
    step();
    check("rd_zero", 32'(bus.cpu_rdata), 32'd0);
    bus.cpu_rd   = 1'b1;
    bus.cpu_addr = 8'd0;
    step();
    check("b2b_a0", 32'(bus.cpu_rdata), 32'h10);
    bus.cpu_addr = 8'd2;
    step();
    check("b2b_a2", 32'(bus.cpu_rdata), 32'h30);
    bus.cpu_rd = 1'b0;
    step();

    // Same-cycle read and write: old data returned
    bus.cpu_addr  = 8'd2;
    bus.cpu_rd    = 1'b1;
    bus.cpu_wr    = 1'b1;
    bus.cpu_wdata = 8'hAB;
    step();
    check("rbw_old", 32'(bus.cpu_rdata), 32'h30);
    bus.cpu_wr = 1'b0;
    step();
    check("rbw_new", 32'(bus.cpu_rdata), 32'hAB);
    bus.cpu_rd = 1'b0;
    step();

    // Loader stall then skip
    rst = 1'b1;
    step();
    rst            = 1'b0;
    bus.prog_valid = 1'b1;
    bus.prog_data  = 8'h55;
    step();
    bus.prog_valid = 1'b0;
    bus.prog_data  = 8'hEE;
    step();
    bus.prog_valid = 1'b1;
    bus.prog_data  = 8'h66;
    step();
    bus.prog_valid = 1'b0;
    check("stall_count", 32'(bus.load_count), 32'd2);
    check("stall_hold", 32'(bus.cpu_hold), 32'd1);
    bus.prog_skip = 1'b1;
    step();
    bus.prog_skip = 1'b0;
    check("skip_hold", 32'(bus.cpu_hold), 32'd0);
    read_one(8'd0, 8'h55, "skip_a0");
    read_one(8'd1, 8'h66, "skip_a1");
    read_one(8'd2, 8'hAB, "skip_a2");

    // Access while held
    rst = 1'b1;
    step();
    rst          = 1'b0;
    bus.cpu_rd   = 1'b1;
    bus.cpu_addr = 8'd0;
    step();
    bus.cpu_rd = 1'b0;
    check("held_rdata", 32'(bus.cpu_rdata), 32'd0);
    check("held_err", 32'(bus.access_err), 32'd1);
    bus.prog_valid = 1'b1;
    foreach (m_mem[i]) begin
      if (i < 3) begin
        bus.prog_data = 8'(8'h10 * (i + 1));
        step();
      end
    end
    bus.prog_valid = 1'b0;
    read_one(8'd0, 8'h10, "held_a0");
    check("err_sticky", 32'(bus.access_err), 32'd1);

    // Reset during a read
    bus.cpu_rd   = 1'b1;
    bus.cpu_addr = 8'd1;
    rst          = 1'b1;
    step();
    check("mid_rdata", 32'(bus.cpu_rdata), 32'd0);
    check("mid_hold", 32'(bus.cpu_hold), 32'd1);
    check("mid_count", 32'(bus.load_count), 32'd0);
    rst           = 1'b0;
    bus.cpu_rd    = 1'b0;
    bus.prog_skip = 1'b1;
    step();
    bus.prog_skip = 1'b0;
    read_one(8'd0, 8'h10, "mid_keep");

    // Give the random window fully known contents
    for (int a = 0; a < 8; a++) begin
      bus.cpu_wr    = 1'b1;
      bus.cpu_addr  = 8'(a);
      bus.cpu_wdata = 8'($urandom);
      step();
    end
    bus.cpu_wr = 1'b0;

    for (int i = 0; i < 400; i++) begin
      rst            = ($urandom_range(49) == 0);
      bus.cpu_rd     = 1'($urandom_range(1));
      bus.cpu_wr     = ($urandom_range(3) == 0);
      bus.cpu_addr   = 8'($urandom_range(7));
      bus.cpu_wdata  = 8'($urandom);
      bus.prog_valid = 1'($urandom_range(1));
      bus.prog_data  = 8'($urandom);
      bus.prog_skip  = ($urandom_range(7) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cpu_mem_responder.md
Name: cpu_mem_responder

Overview:
- Memory-side responder for the tt_um_quick_cpu memory interface. The CPU drives an address and a read strobe; this block returns the byte one cycle later on the CPU data input.
- It replaces the bench-side memory model with synthesizable RTL: a DEPTH x DATA_W byte store with a registered read port and a CPU write port.
- A byte-stream loader fills the store after reset and holds the CPU in reset until loading completes.

Parameters:
- ADDR_W, 8, address width (matches CPU uo_out).
- DATA_W, 8, data width (matches CPU ui_in).
- DEPTH, 256, number of words; must equal 2**ADDR_W.
- LOAD_LEN, 256, bytes accepted by the loader before releasing the CPU; range 1..DEPTH.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- cpu_addr  in  ADDR_W  CPU address (CPU uo_out).
- cpu_rd  in  1  CPU read strobe (CPU mem_read).
- cpu_wr  in  1  CPU write strobe.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_rdata  out  DATA_W  read data to the CPU (drives CPU ui_in).
- cpu_hold  out  1  high = keep CPU in reset; top level drives CPU rst_n = ~cpu_hold.
- prog_valid  in  1  loader byte valid.
- prog_data  in  DATA_W  loader byte.
- prog_ready  out  1  loader can accept a byte.
- prog_skip  in  1  end loading immediately; current contents are kept.
- load_count  out  ADDR_W+1  bytes accepted since the last reset.
- access_err  out  1  sticky flag: CPU access attempted while cpu_hold is high.

Behaviour:
- Two-state FSM: LOAD and RUN.
- Reset (any cycle, including mid-load or mid-read):
  - state = LOAD; load pointer = 0; load_count = 0.
  - cpu_rdata = 0; access_err = 0; cpu_hold = 1; prog_ready = 1 from the first cycle after reset.
  - Memory contents are NOT cleared.
- LOAD state:
  - prog_ready = 1, cpu_hold = 1.
  - On prog_valid & prog_ready: mem[ptr] <= prog_data; ptr and load_count increment.
  - The handshake accepts one byte per cycle; back-to-back transfers are allowed.
  - When the byte accepted is the one with ptr == LOAD_LEN-1, state goes to RUN on the same edge. cpu_hold and prog_ready are 0 from the next cycle.
  - prog_skip = 1 goes to RUN on the next edge. A byte presented with valid in that same cycle is still written.
  - cpu_rdata is held at 0.
  - cpu_rd or cpu_wr sets access_err; the memory is not touched.
- RUN state:
  - prog_ready = 0; prog_valid and prog_skip are ignored; load_count is frozen.
  - Read latency is 1 cycle: cpu_rdata <= cpu_rd ? mem[cpu_addr] : 0, registered.
  - cpu_rdata returns to 0 in the cycle after cpu_rd drops, so the CPU sees 0 on non-read cycles.
  - Write: cpu_wr writes mem[cpu_addr] <= cpu_wdata at the edge.
  - cpu_rd and cpu_wr to the same address in the same cycle: read-before-write. cpu_rdata returns the old byte; the new byte is visible on a later read.
- Address width: cpu_addr is used unmodified. With DEPTH = 2**ADDR_W there is no out-of-range case. The load pointer stops at LOAD_LEN and never wraps.
- access_err clears only on rst.
- All outputs are registered except prog_ready and cpu_hold, which are decoded directly from state.

Test Plan:
- Load: assert rst 2 cycles, then stream 0x10,0x20,0x30 with LOAD_LEN=3 and prog_valid held high -> prog_ready=1 for exactly 3 accepts; cpu_hold falls on the cycle after the third accept; load_count=3.
- Read latency: in RUN, cpu_addr=1, cpu_rd=1 for one cycle -> cpu_rdata=0x20 on the next cycle, then 0 the cycle after. Back-to-back reads of 0,2 -> 0x10 then 0x30 on consecutive cycles.
- Write, and same-cycle read/write: cpu_wr addr 2 data 0xAB together with cpu_rd addr 2 -> cpu_rdata=0x30; a following read of addr 2 -> 0xAB.
- Loader stall and skip: prog_valid toggling 1,0,1 -> exactly 2 bytes written, at addresses 0 and 1. prog_skip pulsed with load_count=2 -> RUN next cycle; addr 2 keeps its previous value.
- Access while held: cpu_rd=1 during LOAD -> cpu_rdata stays 0, access_err=1 and stays 1 through RUN until rst.
- Reset mid-operation: assert rst during a RUN read -> next cycle cpu_rdata=0, cpu_hold=1, load_count=0; after skipping, addr 0 still reads 0x10 (memory retained).
